tx_frame_sched: RTL
===================

# tx_frame_sched

Frame scheduler between the word counter and the UART byte transmitter. Takes a 10-bit word, sends it as a 4-byte frame (sync, high bits, low bits, XOR checksum) via the transmitter's start/done handshake, and enforces an inter-frame gap. After each complete frame it pulses `o_word_done`, which drives the counter's advance input. A watchdog aborts a frame if the transmitter stops responding.

## Interface
- `SYNC_BYTE`, 8'hA5: first byte of every frame.
- `GAP_CYCLES`, 16: idle cycles between frames; 0 means no gap.
- `TIMEOUT_CYCLES`, 1024: maximum cycles spent waiting for one `i_tx_done`; 0 disables the watchdog.

Ports:
- `i_clk`  in  1: clock.
- `i_rst`  in  1: reset, asynchronous, active-high.
- `i_enable`  in  1: allows new frames to start; sampled only in IDLE.
- `i_data`  in  10: word to send; latched at frame start.
- `i_tx_busy`  in  1: transmitter is busy.
- `i_tx_done`  in  1: one-cycle pulse when the transmitter finishes a byte.
- `o_tx_start`  out  1: one-cycle pulse that starts one byte.
- `o_tx_byte`  out  8: byte to transmit; valid from `o_tx_start` until the matching done.
- `o_word_done`  out  1: one-cycle pulse after a frame completes.
- `o_timeout`  out  1: one-cycle pulse when a frame is aborted.
- `o_busy`  out  1: high whenever the FSM is not in IDLE.
- `o_frame_cnt`  out  16: count of completed frames; wraps modulo 2^16.

## Operation
- States: IDLE, WAIT_DONE, GAP. All outputs are registered.
- Frame bytes, using the latched word D:
  - b0 = `SYNC_BYTE`
  - b1 = {6'b0, D[9:8]}
  - b2 = D[7:0]
  - b3 = b0 ^ b1 ^ b2
- IDLE, when `i_enable`=1 and `i_tx_busy`=0:
  - latch `i_data`, set byte index to 0
  - assert `o_tx_start` with `o_tx_byte`=b0
  - go to WAIT_DONE
- IDLE otherwise: hold.
- WAIT_DONE, on `i_tx_done`:
  - If index < 3: increment index, pulse `o_tx_start` with the next byte, clear the watchdog, stay in WAIT_DONE.
  - If index = 3: pulse `o_word_done`, increment `o_frame_cnt`, load the gap counter, go to GAP. If `GAP_CYCLES`=0, go straight to IDLE.
- WAIT_DONE watchdog:
  - Counts cycles since the last `o_tx_start`.
  - When it reaches `TIMEOUT_CYCLES`: pulse `o_timeout`, reset the index, go to GAP (or IDLE if `GAP_CYCLES`=0).
  - No `o_word_done` and no `o_frame_cnt` change on timeout.
- GAP: decrement the gap counter each cycle; at 0, go to IDLE.
- `i_tx_done` in IDLE or GAP is ignored. `i_tx_done` in the same cycle as `o_tx_start` is also ignored.
- Dropping `i_enable` mid-frame does not abort the frame; the frame and its gap complete.
- `i_data` changes after the latch do not affect the frame in flight.
- `o_tx_byte` holds its last value while in IDLE and GAP.

## Timing
- Reset values: state IDLE; `o_tx_start`, `o_word_done`, `o_timeout`, `o_busy` = 0; `o_tx_byte` = 8'h00; `o_frame_cnt` = 0; index, gap counter and watchdog counter = 0.
- Reset asserted mid-frame clears everything immediately. No further `o_tx_start` is issued until IDLE sees `i_enable` after reset releases.
- Frame start: IDLE samples `i_enable`=1 at edge k → `o_tx_start`=1 and `o_busy`=1 during cycle k..k+1. `o_tx_start` clears at edge k+1.
- Between bytes: `i_tx_done` sampled at edge m → next `o_tx_start` during cycle m..m+1.
- Frame end: `o_word_done` is high during the cycle after the edge that samples the final `i_tx_done`. `o_frame_cnt` updates at that same edge.
- The FSM re-enters IDLE exactly `GAP_CYCLES` cycles after `o_word_done` asserts.
- Simultaneous `i_tx_done` and watchdog expiry: done wins, no timeout.
- `o_frame_cnt` rolls from 16'hFFFF to 0 without a flag.

## Test plan
- Reset, `i_data`=10'h2C7, `i_enable`=1 → bytes A5, 02, C7, 60 in order; one `o_word_done`; `o_frame_cnt`=1.
- Transmitter model with 10-cycle done latency, `GAP_CYCLES`=16 → successive `o_tx_start` pulses 11 cycles apart. The next frame's first start comes 17 cycles after `o_word_done`. With the counter in the loop, the second frame carries 10'h2C8.
- Deassert `i_enable` after byte 1 → frame completes (4 bytes, 1 `o_word_done`), then no further `o_tx_start`.
- Withhold `i_tx_done` after byte 2, `TIMEOUT_CYCLES`=1024 → `o_timeout` pulses 1024 cycles after that start; no `o_word_done`; `o_frame_cnt` unchanged. The next frame restarts at A5.
- Assert `i_rst` while waiting for byte 2's done → all outputs at reset values within the same cycle. After release with `i_enable`=1, a fresh frame starts with A5.
- Preload `o_frame_cnt` to 16'hFFFF via 65535 frames (or force) → next frame gives 16'h0000. Extra `i_tx_done` pulses in GAP are ignored.

Source files
------------

// File: rtl/tx_frame_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : tx_frame_sched_if
// Description : Handshake bundle between the frame scheduler, its word
//               source and the UART byte transmitter.
//               slave  : scheduler side (takes i_*, drives o_*)
//               master : environment side (drives i_*, observes o_*)
//               i_enable    : frame start permitted
//               i_data      : 10-bit word to frame
//               i_tx_busy   : transmitter busy
//               i_tx_done   : transmitter finished a byte (pulse)
//               o_tx_start  : start one byte (pulse)
//               o_tx_byte   : byte to transmit
//               o_word_done : frame completed (pulse)
//               o_timeout   : frame aborted by watchdog (pulse)
//               o_busy      : scheduler not idle
//               o_frame_cnt : completed frame count
// Revision    : 1.0 - initial release
// ============================================================================
interface tx_frame_sched_if;
    logic        i_enable;
    logic [9:0]  i_data;
    logic        i_tx_busy;
    logic        i_tx_done;
    logic        o_tx_start;
    logic [7:0]  o_tx_byte;
    logic        o_word_done;
    logic        o_timeout;
    logic        o_busy;
    logic [15:0] o_frame_cnt;

    modport slave (
        input  i_enable, i_data, i_tx_busy, i_tx_done,
        output o_tx_start, o_tx_byte, o_word_done, o_timeout, o_busy, o_frame_cnt
    );

    modport master (
        output i_enable, i_data, i_tx_busy, i_tx_done,
        input  o_tx_start, o_tx_byte, o_word_done, o_timeout, o_busy, o_frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/tx_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : tx_frame_sched
// Description : Sends a 10-bit word as a 4-byte frame (sync, high bits,
//               low bits, XOR checksum) over a start/done byte transmitter,
//               inserts an inter-frame gap, counts completed frames and
//               aborts a frame when the transmitter stops answering.
// Ports       : i_clk - clock
//               i_rst - asynchronous active-high reset
//               bus   - tx_frame_sched_if.slave handshake bundle
// Revision    : 1.0 - initial release
// ============================================================================
module tx_frame_sched #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    tx_frame_sched_if.slave  bus
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_DONE = 2'd1;
    localparam logic [1:0] S_GAP       = 2'd2;

    // Counters only need to hold N-1 (they count down / up to the last value).
    localparam int unsigned c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned c_WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [9:0]         data_q, data_d;
    logic [c_GAP_W-1:0] gap_q, gap_d;
    logic [c_WD_W-1:0]  wd_q, wd_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               word_done_q, word_done_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;

    logic w_launch;
    logic w_frame_end;
    logic w_abort;
    logic w_done_valid;
    logic w_wd_expire;

    function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [9:0] d);
        logic [7:0] b1;
        b1 = {6'b0, d[9:8]};
        case (idx)
            2'd0:    frame_byte = SYNC_BYTE;
            2'd1:    frame_byte = b1;
            2'd2:    frame_byte = d[7:0];
            default: frame_byte = SYNC_BYTE ^ b1 ^ d[7:0];
        endcase
    endfunction

    // A done arriving while the start pulse is still out belongs to no byte.
    assign w_done_valid = bus.i_tx_done && !tx_start_q;
    assign w_wd_expire  = (TIMEOUT_CYCLES != 0) && (wd_q == c_WD_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            data_q      <= 10'd0;
            gap_q       <= '0;
            wd_q        <= '0;
            frame_cnt_q <= 16'd0;
            tx_start_q  <= 1'b0;
            tx_byte_q   <= 8'h00;
            word_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            gap_q       <= gap_d;
            wd_q        <= wd_d;
            frame_cnt_q <= frame_cnt_d;
            tx_start_q  <= tx_start_d;
            tx_byte_q   <= tx_byte_d;
            word_done_q <= word_done_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        gap_d       = gap_q;
        wd_d        = wd_q;
        frame_cnt_d = frame_cnt_q;
        w_launch    = 1'b0;
        w_frame_end = 1'b0;
        w_abort     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_enable && !bus.i_tx_busy) begin
                    data_d   = bus.i_data;
                    idx_d    = 2'd0;
                    wd_d     = '0;
                    w_launch = 1'b1;
                    state_d  = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // Done is checked first so it wins over a same-cycle expiry.
                if (w_done_valid) begin
                    if (idx_q != 2'd3) begin
                        idx_d    = idx_q + 2'd1;
                        wd_d     = '0;
                        w_launch = 1'b1;
                    end else begin
                        w_frame_end = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        idx_d       = 2'd0;
                        wd_d        = '0;
                        gap_d       = c_GAP_LAST;
                        state_d     = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end
                end else if (w_wd_expire) begin
                    w_abort = 1'b1;
                    idx_d   = 2'd0;
                    wd_d    = '0;
                    gap_d   = c_GAP_LAST;
                    state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else begin
                    wd_d = wd_q + c_WD_W'(1);
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - c_GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_start_d  = w_launch;
        tx_byte_d   = w_launch ? frame_byte(idx_d, data_d) : tx_byte_q;
        word_done_d = w_frame_end;
        timeout_d   = w_abort;
        busy_d      = (state_d != S_IDLE);
    end

    assign bus.o_tx_start  = tx_start_q;
    assign bus.o_tx_byte   = tx_byte_q;
    assign bus.o_word_done = word_done_q;
    assign bus.o_timeout   = timeout_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire
